// File: rtl/inhibit_generator_nch_if.sv
// rtl/inhibit_generator_nch_if.sv - bus bundle for the multi-channel inhibit generator
interface inhibit_generator_nch_if #(
  parameter int P_N_CH      = 8,
  parameter int P_N_WIDTH   = 32,
  parameter int P_CNT_WIDTH = 32
);
  // discriminator side
  logic [P_N_CH-1:0]      bits_in;
  logic [P_N_CH-1:0]      bits_out;
  logic [P_N_CH-1:0]      inhibit_bits;
  logic [P_N_CH-1:0]      pulse_out;

  // configuration
  logic [P_N_WIDTH-1:0]   inhibit_len;
  logic                   mode_extend;
  logic [P_N_CH-1:0]      ch_enable;

  // counter snapshot and readout
  logic                   latch;
  logic [5:0]             rd_sel;
  logic [P_CNT_WIDTH-1:0] rd_accepted;
  logic [P_CNT_WIDTH-1:0] rd_vetoed;

  modport master (
    output bits_in, inhibit_len, mode_extend, ch_enable, latch, rd_sel,
    input  bits_out, inhibit_bits, pulse_out, rd_accepted, rd_vetoed
  );

  modport slave (
    input  bits_in, inhibit_len, mode_extend, ch_enable, latch, rd_sel,
    output bits_out, inhibit_bits, pulse_out, rd_accepted, rd_vetoed
  );
endinterface

// File: rtl/inhibit_generator_nch.sv
// rtl/inhibit_generator_nch.sv - per-channel dead-time inhibit with accepted/vetoed edge counters
module inhibit_generator_nch #(
  parameter int P_N_CH      = 8,
  parameter int P_N_WIDTH   = 32,
  parameter int P_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  inhibit_generator_nch_if.slave   io
);

  localparam logic [P_N_WIDTH-1:0]   REM_ONE = {{(P_N_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_CNT_WIDTH-1:0] CNT_MAX = {P_CNT_WIDTH{1'b1}};

  // A channel is idle when its remaining dead time is zero.
  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_INHIBITED = 1'b1
  } ch_state_e;

  // shadowed configuration, one cycle behind the inputs
  logic [P_N_WIDTH-1:0]   len_q;
  logic                   mode_q;
  logic [P_N_CH-1:0]      en_q;

  // bit pipeline and per-channel outputs
  logic [P_N_CH-1:0]      prev_q;
  logic [P_N_CH-1:0]      bits_out_q;
  logic [P_N_CH-1:0]      inhibit_q;
  logic [P_N_CH-1:0]      inhibit_d;
  logic [P_N_CH-1:0]      pulse_q;

  // per-channel dead-time state
  logic [P_N_WIDTH-1:0]   rem_q [P_N_CH];
  logic [P_N_WIDTH-1:0]   rem_d [P_N_CH];
  ch_state_e              ch_state [P_N_CH];
  logic [P_N_CH-1:0]      edge_w;
  logic [P_N_CH-1:0]      accept_d;
  logic [P_N_CH-1:0]      veto_d;

  // live counters and their snapshots
  logic [P_CNT_WIDTH-1:0] acc_q  [P_N_CH];
  logic [P_CNT_WIDTH-1:0] acc_d  [P_N_CH];
  logic [P_CNT_WIDTH-1:0] vet_q  [P_N_CH];
  logic [P_CNT_WIDTH-1:0] vet_d  [P_N_CH];
  logic [P_CNT_WIDTH-1:0] snap_acc_q [P_N_CH];
  logic [P_CNT_WIDTH-1:0] snap_vet_q [P_N_CH];

  // readout registers
  logic [P_CNT_WIDTH-1:0] rd_acc_q;
  logic [P_CNT_WIDTH-1:0] rd_acc_d;
  logic [P_CNT_WIDTH-1:0] rd_vet_q;
  logic [P_CNT_WIDTH-1:0] rd_vet_d;

  // Saturating +1: a counter that reached all-ones stays there.
  function automatic logic [P_CNT_WIDTH-1:0] sat_inc(input logic [P_CNT_WIDTH-1:0] v,
                                                      input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

  // Shadow the configuration and delay the raw bits by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      mode_q     <= 1'b0;
      en_q       <= '0;
      prev_q     <= '0;
      bits_out_q <= '0;
    end else begin
      len_q      <= io.inhibit_len;
      mode_q     <= io.mode_extend;
      en_q       <= io.ch_enable;
      prev_q     <= io.bits_in;
      bits_out_q <= io.bits_in;
    end
  end

  // Per-channel next dead time and accept/veto decision for this sampling edge.
  always_comb begin
    edge_w    = '0;
    accept_d  = '0;
    veto_d    = '0;
    inhibit_d = '0;
    for (int c = 0; c < P_N_CH; c++) begin
      edge_w[c]   = io.bits_in[c] & ~prev_q[c];
      rem_d[c]    = rem_q[c];
      ch_state[c] = (rem_q[c] != '0) ? ST_INHIBITED : ST_IDLE;
      if (!en_q[c]) begin
        // a disabled channel drops any dead time and ignores edges
        rem_d[c] = '0;
      end else if (len_q == '0) begin
        // zero length: inhibit off, every edge passes
        rem_d[c]    = '0;
        accept_d[c] = edge_w[c];
      end else begin
        case (ch_state[c])
          ST_IDLE: begin
            if (edge_w[c]) begin
              rem_d[c]    = len_q;
              accept_d[c] = 1'b1;
            end
          end
          ST_INHIBITED: begin
            rem_d[c] = rem_q[c] - REM_ONE;
            if (edge_w[c]) begin
              veto_d[c] = 1'b1;
              if (mode_q) begin
                rem_d[c] = len_q;
              end
            end
          end
          default: rem_d[c] = '0;
        endcase
      end
      inhibit_d[c] = (rem_d[c] != '0);
    end
  end

  // Dead-time counters, inhibit flags and acceptance pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inhibit_q <= '0;
      pulse_q   <= '0;
      for (int c = 0; c < P_N_CH; c++) begin
        rem_q[c] <= '0;
      end
    end else begin
      inhibit_q <= inhibit_d;
      pulse_q   <= accept_d;
      for (int c = 0; c < P_N_CH; c++) begin
        rem_q[c] <= rem_d[c];
      end
    end
  end

  // Counter update: on latch the live value restarts from this cycle's own contribution.
  always_comb begin
    for (int c = 0; c < P_N_CH; c++) begin
      if (io.latch) begin
        acc_d[c] = accept_d[c] ? CNT_ONE : '0;
        vet_d[c] = veto_d[c]   ? CNT_ONE : '0;
      end else begin
        acc_d[c] = sat_inc(acc_q[c], accept_d[c]);
        vet_d[c] = sat_inc(vet_q[c], veto_d[c]);
      end
    end
  end

  // Live counters and snapshots; snapshots take the pre-latch live values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < P_N_CH; c++) begin
        acc_q[c]      <= '0;
        vet_q[c]      <= '0;
        snap_acc_q[c] <= '0;
        snap_vet_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < P_N_CH; c++) begin
        acc_q[c] <= acc_d[c];
        vet_q[c] <= vet_d[c];
        if (io.latch) begin
          snap_acc_q[c] <= acc_q[c];
          snap_vet_q[c] <= vet_q[c];
        end
      end
    end
  end

  // Snapshot select; an index past the last channel reads as zero.
  always_comb begin
    rd_acc_d = '0;
    rd_vet_d = '0;
    for (int c = 0; c < P_N_CH; c++) begin
      if (int'(io.rd_sel) == c) begin
        rd_acc_d = snap_acc_q[c];
        rd_vet_d = snap_vet_q[c];
      end
    end
  end

  // Registered readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_acc_q <= '0;
      rd_vet_q <= '0;
    end else begin
      rd_acc_q <= rd_acc_d;
      rd_vet_q <= rd_vet_d;
    end
  end

  assign io.bits_out     = bits_out_q;
  assign io.inhibit_bits = inhibit_q;
  assign io.pulse_out    = pulse_q;
  assign io.rd_accepted  = rd_acc_q;
  assign io.rd_vetoed    = rd_vet_q;

endmodule

// File: tb/tb_inhibit_generator_nch.sv
// tb/tb_inhibit_generator_nch.sv - self-checking bench for inhibit_generator_nch
module tb_inhibit_generator_nch;

  localparam int NCH  = 8;
  localparam int NW   = 16;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inhibit_generator_nch_if #(.P_N_CH(NCH), .P_N_WIDTH(NW), .P_CNT_WIDTH(CW)) bus ();

  inhibit_generator_nch #(.P_N_CH(NCH), .P_N_WIDTH(NW), .P_CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: each channel keeps the absolute edge index at which its dead time ends
  longint t = 0;
  longint busy [NCH];
  bit     m_prev [NCH];
  int     sh_len;
  bit     sh_mode;
  bit [NCH-1:0] sh_en;
  int acc_m [NCH], vet_m [NCH], snap_a [NCH], snap_v [NCH];
  logic [NCH-1:0] e_bits, e_pulse, e_inh;
  int e_rda, e_rdv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      busy[c] = t; m_prev[c] = 0;
      acc_m[c] = 0; vet_m[c] = 0; snap_a[c] = 0; snap_v[c] = 0;
    end
    sh_len = 0; sh_mode = 0; sh_en = '0;
    e_bits = '0; e_pulse = '0; e_inh = '0; e_rda = 0; e_rdv = 0;
  endtask

  task automatic model_edge();
    int idx;
    bit e, ai, vi;
    t++;
    idx    = int'(bus.rd_sel);
    e_bits = bus.bits_in;
    e_rda  = (idx < NCH) ? snap_a[idx] : 0;
    e_rdv  = (idx < NCH) ? snap_v[idx] : 0;
    for (int c = 0; c < NCH; c++) begin
      e = bus.bits_in[c] && !m_prev[c];
      ai = 0; vi = 0;
      if (!sh_en[c]) busy[c] = t;
      else if (sh_len == 0) begin busy[c] = t; ai = e; end
      else if (busy[c] < t) begin
        if (e) begin busy[c] = t + sh_len; ai = 1; end
      end else if (e) begin
        vi = 1;
        if (sh_mode) busy[c] = t + sh_len;
      end
      e_pulse[c] = ai;
      e_inh[c]   = (busy[c] > t);
      if (bus.latch) begin
        snap_a[c] = acc_m[c]; snap_v[c] = vet_m[c];
        acc_m[c] = int'(ai); vet_m[c] = int'(vi);
      end else begin
        acc_m[c] = (acc_m[c] + int'(ai) > CMAX) ? CMAX : acc_m[c] + int'(ai);
        vet_m[c] = (vet_m[c] + int'(vi) > CMAX) ? CMAX : vet_m[c] + int'(vi);
      end
    end
    sh_len  = int'(bus.inhibit_len);
    sh_mode = bus.mode_extend;
    sh_en   = bus.ch_enable;
    for (int c = 0; c < NCH; c++) m_prev[c] = bus.bits_in[c];
  endtask

  task automatic check_all();
    chk("bits_out", bus.bits_out, e_bits);
    chk("pulse_out", bus.pulse_out, e_pulse);
    chk("inhibit_bits", bus.inhibit_bits, e_inh);
    chk("rd_accepted", bus.rd_accepted, e_rda);
    chk("rd_vetoed", bus.rd_vetoed, e_rdv);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [NCH-1:0] b, input int len, input bit mode,
                       input logic [NCH-1:0] en, input bit lat, input int sel);
    bus.bits_in     = b;
    bus.inhibit_len = NW'(len);
    bus.mode_extend = mode;
    bus.ch_enable   = en;
    bus.latch       = lat;
    bus.rd_sel      = 6'(sel);
  endtask

  // asserted off the clock edge; outputs must drop without waiting for a clock
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pulse", bus.pulse_out, 0);
    chk("rst_inhibit", bus.inhibit_bits, 0);
    chk("rst_bits_out", bus.bits_out, 0);
    chk("rst_rd_acc", bus.rd_accepted, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit  b;
    int  len;
    bit  mode;
    bit  lat;
    bit  p0;
    bit  i0;
    int  ra;
    int  rv;
  } vec_t;
  vec_t vecs [$];

  task automatic add(input bit b, input int len, input bit mode, input bit lat,
                     input bit p0, input bit i0, input int ra, input int rv);
    vec_t v;
    v.b = b; v.len = len; v.mode = mode; v.lat = lat;
    v.p0 = p0; v.i0 = i0; v.ra = ra; v.rv = rv;
    vecs.push_back(v);
  endtask

  initial begin
    drive('0, 0, 0, '0, 0, 0);
    model_reset();
    do_reset();

    // L=4 non-extending: lone edge, then edges two apart, then extending mode
    add(0,4,0,0, 0,0, 0,0);
    add(1,4,0,0, 1,1, 0,0);
    add(0,4,0,0, 0,1, 0,0);
    add(0,4,0,0, 0,1, 0,0);
    add(0,4,0,0, 0,1, 0,0);
    add(0,4,0,0, 0,0, 0,0);
    add(0,4,0,1, 0,0, 0,0);
    add(0,4,0,0, 0,0, 1,0);
    add(1,4,0,0, 1,1, 1,0);
    add(0,4,0,0, 0,1, 1,0);
    add(1,4,0,0, 0,1, 1,0);
    add(0,4,0,0, 0,1, 1,0);
    add(1,4,0,0, 0,0, 1,0);
    add(0,4,0,1, 0,0, 1,0);
    add(0,4,0,0, 0,0, 1,2);
    add(0,4,1,0, 0,0, 1,2);
    add(1,4,1,0, 1,1, 1,2);
    add(0,4,1,0, 0,1, 1,2);
    add(1,4,1,0, 0,1, 1,2);
    add(0,4,1,0, 0,1, 1,2);
    add(1,4,1,0, 0,1, 1,2);
    add(0,4,1,0, 0,1, 1,2);
    add(0,4,1,0, 0,1, 1,2);
    add(0,4,1,0, 0,1, 1,2);
    add(0,4,1,0, 0,0, 1,2);
    add(0,4,1,1, 0,0, 1,2);
    add(0,4,1,0, 0,0, 1,2);
    foreach (vecs[i]) begin
      drive({NCH{vecs[i].b}}, vecs[i].len, vecs[i].mode, '1, vecs[i].lat, 0);
      step();
      chk($sformatf("vec%0d_pulse0", i), bus.pulse_out[0], vecs[i].p0);
      chk($sformatf("vec%0d_inh0", i), bus.inhibit_bits[0], vecs[i].i0);
      chk($sformatf("vec%0d_rd_acc", i), bus.rd_accepted, vecs[i].ra);
      chk($sformatf("vec%0d_rd_vet", i), bus.rd_vetoed, vecs[i].rv);
    end

    // L=0: every edge on every channel pulses, no inhibit
    drive('0, 0, 0, '1, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive((i % 2 == 0) ? '1 : '0, 0, 0, '1, 0, 0);
      step();
      chk("len0_pulse", bus.pulse_out, (i % 2 == 0) ? 8'hFF : 8'h00);
      chk("len0_inhibit", bus.inhibit_bits, 0);
    end
    drive('0, 0, 0, '1, 1, 0);
    step();
    for (int c = 0; c < NCH; c++) begin
      drive('0, 0, 0, '1, 0, c);
      step();
      chk($sformatf("len0_acc_ch%0d", c), bus.rd_accepted, 10);
      chk($sformatf("len0_vet_ch%0d", c), bus.rd_vetoed, 0);
    end

    // saturation, and a latch coinciding with an accepted edge
    drive('0, 0, 0, '1, 1, 0);
    step();
    for (int i = 0; i < 34; i++) begin
      drive((i % 2 == 0) ? 8'h01 : 8'h00, 0, 0, '1, 0, 0);
      step();
    end
    drive(8'h01, 0, 0, '1, 1, 0);
    step();
    drive('0, 0, 0, '1, 0, 0);
    step();
    chk("sat_snapshot", bus.rd_accepted, 15);
    drive('0, 0, 0, '1, 1, 0);
    step();
    drive('0, 0, 0, '1, 0, 0);
    step();
    chk("sat_new_interval", bus.rd_accepted, 1);
    drive('0, 0, 0, '1, 0, 8);
    step();
    chk("rd_sel8", bus.rd_accepted, 0);
    drive('0, 0, 0, '1, 0, 63);
    step();
    chk("rd_sel63_acc", bus.rd_accepted, 0);
    chk("rd_sel63_vet", bus.rd_vetoed, 0);

    // enable cleared mid-inhibit
    drive('0, 10, 0, '1, 0, 0);
    step();
    step();
    drive(8'h01, 10, 0, '1, 0, 0);
    step();
    chk("en_accept", bus.pulse_out[0], 1);
    drive('0, 10, 0, '1, 0, 0);
    step();
    step();
    drive('0, 10, 0, 8'hFE, 0, 0);
    step();
    chk("en_shadow_lag", bus.inhibit_bits[0], 1);
    step();
    chk("en_cleared", bus.inhibit_bits[0], 0);

    // asynchronous reset while a pulse and inhibit are live
    drive('0, 10, 0, '1, 0, 0);
    step();
    drive(8'h03, 10, 0, '1, 0, 0);
    step();
    chk("pre_rst_pulse", bus.pulse_out, 8'h03);
    do_reset();
    step();
    step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.bits_in = NCH'($urandom);
      if ($urandom_range(0, 19) == 0) bus.inhibit_len = NW'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) bus.mode_extend = ~bus.mode_extend;
      if ($urandom_range(0, 29) == 0) bus.ch_enable = NCH'($urandom) | 8'h0F;
      bus.latch  = ($urandom_range(0, 11) == 0);
      bus.rd_sel = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 9));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inhibit_generator_nch.md
# inhibit_generator_nch

Multi-channel, parametrised successor to the 1-bit scaler inhibit generator. It sits between the discriminator bit streams and the discriminator scalers. For each channel it applies a programmable dead time after an accepted rising edge, in either non-extending or extending (paralyzable) mode. It also keeps per-channel accepted and vetoed edge counts, which are snapshotted on a latch strobe and read back through a channel-select mux.

## Interface
- P_N_CH, 8, number of discriminator channels (1..64)
- P_N_WIDTH, 32, width of inhibit length and per-channel dead-time counter
- P_CNT_WIDTH, 32, width of accepted/vetoed edge counters
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- bits_in  in  P_N_CH  discriminator bits, one per channel
- inhibit_len  in  P_N_WIDTH  dead time in clk cycles, shared by all channels; 0 disables inhibit
- mode_extend  in  1  0 = non-extending dead time, 1 = extending dead time
- ch_enable  in  P_N_CH  per-channel enable mask
- latch  in  1  single-cycle strobe; snapshot and clear counters
- rd_sel  in  6  channel index for readout
- bits_out  out  P_N_CH  bits_in delayed one cycle
- inhibit_bits  out  P_N_CH  per-channel inhibit (dead time) active
- pulse_out  out  P_N_CH  one-cycle pulse per accepted edge
- rd_accepted  out  P_CNT_WIDTH  snapshot accepted count of channel rd_sel
- rd_vetoed  out  P_CNT_WIDTH  snapshot vetoed count of channel rd_sel

## Operation
- Reset is asynchronous. It clears all registers, all outputs, the counters, the snapshots and the previous-bit registers to 0.
- inhibit_len, mode_extend and ch_enable are registered once (shadow regs, 1-cycle delay) before use. Changes never truncate or extend an inhibit already in progress, except as stated for enable and len=0.
- Edge detect, per channel c:
  - edge[c] = bits_in[c] & ~prev[c], where prev[c] is bits_in[c] registered.
  - This is evaluated at the sampling clock edge k.
- Per-channel state: IDLE (rem == 0) or INHIBITED (rem > 0); rem is a P_N_WIDTH down-counter.
- Accepted edge:
  - Conditions: edge, channel enabled, shadow len L > 0, channel IDLE.
  - Action: rem <= L, pulse_out[c] <= 1, accepted counter +1.
- Vetoed edge:
  - Conditions: edge, channel enabled, channel INHIBITED.
  - Action: vetoed counter +1.
  - If mode_extend = 1, also rem <= L, so dead time restarts at full length.
  - If mode_extend = 0, rem is unaffected.
- INHIBITED with no reloading edge: rem <= rem - 1; the channel returns to IDLE when rem reaches 0.
- inhibit_bits[c] is registered and equals (next rem != 0). It is therefore high for exactly L cycles after a lone accepted edge.
- L = 0: rem is forced to 0 and inhibit_bits to 0. Every edge on an enabled channel is accepted, with a pulse and the accepted counter incremented.
- Channel disabled:
  - Its edges are neither accepted nor counted.
  - rem and inhibit_bits clear on the cycle after the shadow enable drops.
- Counters saturate at 2^P_CNT_WIDTH - 1; they never wrap.
- latch = 1 in cycle k, all channels simultaneously:
  - Live counters are copied to the snapshots.
  - Live counters are then set to the count contributed by cycle k itself (0 or 1), so no edge is lost.
- Readout: rd_accepted/rd_vetoed are registered muxes of the snapshots by rd_sel. rd_sel >= P_N_CH returns 0.
- bits_out is unaffected by inhibit. Gating is the consumer's job, using inhibit_bits or pulse_out.

## Timing
- bits_out: 1-cycle latency from bits_in.
- Edge sampled at clock edge k leads to pulse_out and inhibit_bits high after edge k, in the same cycle as the bits_out rising edge.
- Non-extending mode: inhibit_bits stays high for L cycles, then low. An edge sampled on the final inhibited cycle is vetoed. An edge on the first IDLE cycle is accepted, giving back-to-back inhibit with no low gap.
- Extending mode: inhibit_bits falls L cycles after the last edge seen while inhibited.
- Shadow inputs take 1 cycle; a new L applies to loads from the second clock edge after the change.
- Readout: 1-cycle latency from rd_sel; snapshot values are visible on readout 1 cycle after the latch edge.
- Asynchronous reset mid-inhibit: inhibit_bits and pulse_out drop immediately. The first edge after reset release needs bits_in low-to-high relative to prev = 0, so a level already high at release counts as an edge.

## Test plan
- L=4, mode 0, ch0: single pulse at edge 10 -> pulse_out[0] one cycle after edge 10; inhibit_bits[0] high cycles 11-14; accepted=1, vetoed=0 after latch.
- L=4, mode 0: edges at 10, 12, 14 -> 10 accepted, 12 and 14 vetoed, inhibit 11-14 only; accepted=1, vetoed=2.
- L=4, mode 1: edges at 10, 12, 14 -> inhibit 11-18; accepted=1, vetoed=2.
- L=0: edges every 2 cycles on all 8 channels -> every edge pulses; inhibit_bits stays 0; accepted counts match edge counts exactly.
- latch coincident with an accepted edge, P_CNT_WIDTH=4 driven past 15 -> snapshot saturates at 15; the new interval starts at 1.
- Async rst asserted mid-inhibit and ch_enable cleared mid-inhibit -> outputs 0 immediately on rst; inhibit_bits clears 1 cycle after the shadow enable drops; rd_sel=63 reads 0.
